// File: rtl/color_cycle_pkg.sv
// color_cycle_pkg
//   Shared types and constants for the four-colour sequencing controller.
//   - color_state_t : state codes Idle 0, Blue 1, Red 2, Green 3
//   - cmd_t         : command codes HOLD 0, START 1, ADVANCE 2, STOP 3
//   - OUT_*         : Moore output encodings (zero-extended to OUT_WIDTH)
//   - color_succ    : successor colour used by ADVANCE and auto-advance
package color_cycle_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLUE  = 2'd1,
        ST_RED   = 2'd2,
        ST_GREEN = 2'd3
    } color_state_t;

    typedef enum logic [1:0] {
        CMD_HOLD    = 2'd0,
        CMD_START   = 2'd1,
        CMD_ADVANCE = 2'd2,
        CMD_STOP    = 2'd3
    } cmd_t;

    localparam logic [2:0] OUT_IDLE  = 3'd0;
    localparam logic [2:0] OUT_BLUE  = 3'd1;
    localparam logic [2:0] OUT_RED   = 3'd2;
    localparam logic [2:0] OUT_GREEN = 3'd4;

    // Idle has no successor: advancing from Idle is a no-op.
    function automatic color_state_t color_succ(input color_state_t s);
        color_state_t n;
        case (s)
            ST_BLUE:  n = ST_RED;
            ST_RED:   n = ST_GREEN;
            ST_GREEN: n = ST_BLUE;
            default:  n = ST_IDLE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/color_dwell_timer.sv
// color_dwell_timer
//   Counts cycles spent in the current colour state and flags when the
//   programmed dwell has elapsed.
//   Ports:
//     clk, rst      clock, asynchronous active-low reset
//     clear         force timer to 0 (state change or Idle)
//     hold          freeze timer this cycle
//     dwell_cycles  live dwell length; 0 disables expiry
//     expire        timer == dwell_cycles-1 (combinational compare of the register)
//   The timer wraps at 2^DWELL_WIDTH, so lowering dwell_cycles below the
//   current count delays the next expiry until after the wrap.
module color_dwell_timer #(
    parameter int DWELL_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   hold,
    input  logic [DWELL_WIDTH-1:0] dwell_cycles,
    output logic                   expire
);

    logic [DWELL_WIDTH-1:0] r_timer;
    logic [DWELL_WIDTH-1:0] w_last;

    // Last timer value before expiry for the current dwell setting.
    always_comb begin
        w_last = dwell_cycles - DWELL_WIDTH'(1'b1);
        if (dwell_cycles != {DWELL_WIDTH{1'b0}}) begin
            expire = (r_timer == w_last);
        end else begin
            expire = 1'b0;
        end
    end

    // Timer register: clear beats hold, otherwise count with natural wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_timer <= {DWELL_WIDTH{1'b0}};
        end else if (clear) begin
            r_timer <= {DWELL_WIDTH{1'b0}};
        end else if (hold) begin
            r_timer <= r_timer;
        end else begin
            r_timer <= r_timer + DWELL_WIDTH'(1'b1);
        end
    end

endmodule

// File: rtl/color_cycle_fsm.sv
// color_cycle_fsm
//   Four-state (Idle, Blue, Red, Green) Moore sequencing controller with a
//   command interface, per-state dwell timer, saturating Red-occupancy
//   counter and lap-complete pulse.
//   Ports:
//     clk, rst       clock, asynchronous active-low reset
//     cmd_valid/cmd  command (HOLD, START, ADVANCE, STOP), acts when valid
//     dwell_cycles   cycles per colour before auto-advance; 0 disables it
//     out            Moore encoding of state (Idle 0, Blue 1, Red 2, Green 4)
//     state          current state code
//     red_count      saturating count of cycles spent in Red
//     red_count_sat  sticky, set when red_count reaches all-ones
//     cycle_done     one-cycle pulse coincident with entering Blue from Green
//     lap_count      (only with COLOR_CYCLE_FSM_LAP_CNT_EN) laps completed,
//                    wraps, cleared by STOP
//   Optional feature macro: COLOR_CYCLE_FSM_LAP_CNT_EN.
module color_cycle_fsm
    import color_cycle_pkg::*;
#(
    parameter int CNT_WIDTH   = 8,
    parameter int DWELL_WIDTH = 4,
    parameter int OUT_WIDTH   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    input  logic [1:0]             cmd,
    input  logic [DWELL_WIDTH-1:0] dwell_cycles,
    output logic [OUT_WIDTH-1:0]   out,
    output logic [1:0]             state,
    output logic [CNT_WIDTH-1:0]   red_count,
    output logic                   red_count_sat,
    output logic                   cycle_done
`ifdef COLOR_CYCLE_FSM_LAP_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]   lap_count
`endif
);

    color_state_t           r_state;
    color_state_t           w_next_state;
    logic [OUT_WIDTH-1:0]   r_out;
    logic [CNT_WIDTH-1:0]   r_red_count;
    logic                   r_red_sat;
    logic                   r_cycle_done;
    cmd_t                   w_cmd;
    logic                   w_stop;
    logic                   w_advance;
    logic                   w_hold;
    logic                   w_start;
    logic                   w_expire;
    logic                   w_timer_clear;
    logic                   w_lap_event;

    function automatic logic [OUT_WIDTH-1:0] encode_out(input color_state_t s);
        logic [OUT_WIDTH-1:0] o;
        case (s)
            ST_BLUE:  o = OUT_WIDTH'(OUT_BLUE);
            ST_RED:   o = OUT_WIDTH'(OUT_RED);
            ST_GREEN: o = OUT_WIDTH'(OUT_GREEN);
            default:  o = OUT_WIDTH'(OUT_IDLE);
        endcase
        return o;
    endfunction

    // Command decode; every command is qualified by cmd_valid.
    always_comb begin
        w_cmd     = cmd_t'(cmd);
        w_stop    = cmd_valid && (w_cmd == CMD_STOP);
        w_advance = cmd_valid && (w_cmd == CMD_ADVANCE);
        w_hold    = cmd_valid && (w_cmd == CMD_HOLD);
        w_start   = cmd_valid && (w_cmd == CMD_START);
    end

    // Next-state priority: STOP, ADVANCE, HOLD, START, auto-advance.
    // ADVANCE and a timer match in the same cycle yield one step only.
    always_comb begin
        w_next_state = r_state;
        if (w_stop) begin
            w_next_state = ST_IDLE;
        end else if (w_advance) begin
            w_next_state = color_succ(r_state);
        end else if (w_hold) begin
            w_next_state = r_state;
        end else if (w_start && (r_state == ST_IDLE)) begin
            w_next_state = ST_BLUE;
        end else if (w_expire && (r_state != ST_IDLE)) begin
            w_next_state = color_succ(r_state);
        end else begin
            w_next_state = r_state;
        end
    end

    // Timer restarts on every state change and stays at 0 while Idle.
    always_comb begin
        w_timer_clear = (w_next_state != r_state) || (r_state == ST_IDLE);
        w_lap_event   = (r_state == ST_GREEN) && (w_next_state == ST_BLUE);
    end

    color_dwell_timer #(
        .DWELL_WIDTH (DWELL_WIDTH)
    ) u_dwell_timer (
        .clk          (clk),
        .rst          (rst),
        .clear        (w_timer_clear),
        .hold         (w_hold),
        .dwell_cycles (dwell_cycles),
        .expire       (w_expire)
    );

    // State register; out is registered from the next state so it always
    // matches the state it encodes, and cycle_done marks the Green->Blue edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_out        <= {OUT_WIDTH{1'b0}};
            r_cycle_done <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_out        <= encode_out(w_next_state);
            r_cycle_done <= w_lap_event;
        end
    end

    // Red occupancy: STOP clears first; otherwise count while in Red, saturating.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_red_count <= {CNT_WIDTH{1'b0}};
            r_red_sat   <= 1'b0;
        end else if (w_stop) begin
            r_red_count <= {CNT_WIDTH{1'b0}};
            r_red_sat   <= 1'b0;
        end else if ((r_state == ST_RED) && (r_red_count != {CNT_WIDTH{1'b1}})) begin
            r_red_count <= r_red_count + CNT_WIDTH'(1'b1);
            r_red_sat   <= r_red_sat ||
                           ((r_red_count + CNT_WIDTH'(1'b1)) == {CNT_WIDTH{1'b1}});
        end else begin
            r_red_count <= r_red_count;
            r_red_sat   <= r_red_sat;
        end
    end

`ifdef COLOR_CYCLE_FSM_LAP_CNT_EN
    logic [CNT_WIDTH-1:0] r_lap_count;

    // Lap counter steps on the same edge that raises cycle_done; wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lap_count <= {CNT_WIDTH{1'b0}};
        end else if (w_stop) begin
            r_lap_count <= {CNT_WIDTH{1'b0}};
        end else if (w_lap_event) begin
            r_lap_count <= r_lap_count + CNT_WIDTH'(1'b1);
        end else begin
            r_lap_count <= r_lap_count;
        end
    end

    assign lap_count = r_lap_count;
`else
    // Lap counting is not built in this configuration.
`endif

    assign out           = r_out;
    assign state         = r_state;
    assign red_count     = r_red_count;
    assign red_count_sat = r_red_sat;
    assign cycle_done    = r_cycle_done;

endmodule

// File: tb/tb_color_cycle_fsm.sv
// Self-checking bench for color_cycle_fsm. Expected outputs come from a
// small behavioural model, pushed to a scoreboard queue when stimulus is
// driven and compared after the clock edge. Optional feature macro:
// COLOR_CYCLE_FSM_LAP_CNT_EN.
module tb_color_cycle_fsm;

    localparam int CW = 3;
    localparam int DW = 4;
    localparam int OW = 4;

    localparam int C_HOLD  = 0;
    localparam int C_START = 1;
    localparam int C_ADV   = 2;
    localparam int C_STOP  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic [1:0]    cmd;
    logic [DW-1:0] dwell_cycles;
    logic [OW-1:0] out;
    logic [1:0]    state;
    logic [CW-1:0] red_count;
    logic          red_count_sat;
    logic          cycle_done;
`ifdef COLOR_CYCLE_FSM_LAP_CNT_EN
    logic [CW-1:0] lap_count;
`endif

    always #5 clk = ~clk;

    color_cycle_fsm #(
        .CNT_WIDTH   (CW),
        .DWELL_WIDTH (DW),
        .OUT_WIDTH   (OW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd           (cmd),
        .dwell_cycles  (dwell_cycles),
        .out           (out),
        .state         (state),
        .red_count     (red_count),
        .red_count_sat (red_count_sat),
        .cycle_done    (cycle_done)
`ifdef COLOR_CYCLE_FSM_LAP_CNT_EN
        ,
        .lap_count     (lap_count)
`endif
    );

    typedef struct {
        int st;
        int o;
        int red;
        int sat;
        int done;
        int lap;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_mis = 0;
    int   m_state, m_timer, m_red, m_sat, m_done, m_lap;
    int   out_seq[$];

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int out_of(input int s);
        case (s)
            1: return 1;
            2: return 2;
            3: return 4;
            default: return 0;
        endcase
    endfunction

    function automatic int succ_of(input int s);
        case (s)
            1: return 2;
            2: return 3;
            3: return 1;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_state = 0; m_timer = 0; m_red = 0; m_sat = 0; m_done = 0; m_lap = 0;
    endtask

    // One clock of the reference behaviour; pushes the post-edge expectation.
    task automatic model_step(input bit v, input int c, input int d);
        int   ns;
        int   cmax;
        exp_t e;
        cmax = (1 << CW) - 1;
        ns = m_state;
        if (v && c == C_STOP)                    ns = 0;
        else if (v && c == C_ADV)                ns = succ_of(m_state);
        else if (v && c == C_HOLD)               ns = m_state;
        else if (v && c == C_START && m_state == 0) ns = 1;
        else if (m_state != 0 && d != 0 && m_timer == d - 1) ns = succ_of(m_state);
        m_done = (m_state == 3 && ns == 1) ? 1 : 0;
        if (v && c == C_STOP) begin
            m_red = 0; m_sat = 0; m_lap = 0;
        end else begin
            if (m_state == 2 && m_red != cmax) begin
                m_red = m_red + 1;
                if (m_red == cmax) m_sat = 1;
            end
            if (m_done == 1) m_lap = (m_lap + 1) % (1 << CW);
        end
        if (ns != m_state || m_state == 0) m_timer = 0;
        else if (!(v && c == C_HOLD))      m_timer = (m_timer + 1) % (1 << DW);
        m_state = ns;
        e.st = m_state; e.o = out_of(m_state); e.red = m_red;
        e.sat = m_sat; e.done = m_done; e.lap = m_lap;
        sb_q.push_back(e);
    endtask

    task automatic compare_outputs();
        exp_t e;
        check_eq("sb_depth", sb_q.size(), 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq("state", int'(state), e.st);
            check_eq("out", int'(out), e.o);
            check_eq("red_count", int'(red_count), e.red);
            check_eq("red_count_sat", int'(red_count_sat), e.sat);
            check_eq("cycle_done", int'(cycle_done), e.done);
`ifdef COLOR_CYCLE_FSM_LAP_CNT_EN
            check_eq("lap_count", int'(lap_count), e.lap);
`endif
        end
    endtask

    task automatic cycle(input bit v, input int c, input int d);
        @(negedge clk);
        cmd_valid    = v;
        cmd          = c[1:0];
        dwell_cycles = d[DW-1:0];
        model_step(v, c, d);
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    task automatic idle_cycles(input int n, input int d);
        for (int i = 0; i < n; i++) cycle(1'b0, C_HOLD, d);
    endtask

    // Asynchronous reset between edges; outputs must clear without a clock.
    task automatic async_reset(input string tag);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_eq({tag, "_state"}, int'(state), 0);
        check_eq({tag, "_out"}, int'(out), 0);
        check_eq({tag, "_red"}, int'(red_count), 0);
        check_eq({tag, "_sat"}, int'(red_count_sat), 0);
        check_eq({tag, "_done"}, int'(cycle_done), 0);
`ifdef COLOR_CYCLE_FSM_LAP_CNT_EN
        check_eq({tag, "_lap"}, int'(lap_count), 0);
`endif
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int last_out;
        rst = 1'b1; cmd_valid = 1'b0; cmd = 2'd0; dwell_cycles = {DW{1'b0}};
        model_reset();
        #3;
        async_reset("reset");

        // Auto-advance lap with dwell 3; record the distinct out values.
        cycle(1'b1, C_START, 3);
        out_seq.push_back(int'(out));
        last_out = int'(out);
        for (int i = 0; i < 9; i++) begin
            cycle(1'b0, C_HOLD, 3);
            if (int'(out) != last_out) begin
                out_seq.push_back(int'(out));
                last_out = int'(out);
            end
        end
        check_eq("lap_done_pulse", int'(cycle_done), 1);
        check_eq("out_seq_len", out_seq.size(), 4);
        if (out_seq.size() == 4) begin
            check_eq("out_seq0", out_seq[0], 1);
            check_eq("out_seq1", out_seq[1], 2);
            check_eq("out_seq2", out_seq[2], 4);
            check_eq("out_seq3", out_seq[3], 1);
        end
        cycle(1'b0, C_HOLD, 3);
        check_eq("done_one_cycle", int'(cycle_done), 0);

        // Manual ADVANCE every 5 cycles, auto-advance disabled.
        cycle(1'b1, C_STOP, 0);
        cycle(1'b1, C_START, 0);
        idle_cycles(4, 0);
        cycle(1'b1, C_ADV, 0);
        idle_cycles(4, 0);
        check_eq("no_auto_in_red", int'(state), 2);
        cycle(1'b1, C_ADV, 0);
        check_eq("red_visit_count", int'(red_count), 5);
        idle_cycles(4, 0);
        cycle(1'b1, C_ADV, 0);
        check_eq("manual_lap_state", int'(state), 1);

        // HOLD in Red freezes the timer; red_count keeps counting and saturates.
        cycle(1'b1, C_STOP, 4);
        cycle(1'b1, C_START, 4);
        cycle(1'b1, C_ADV, 4);
        for (int i = 0; i < 10; i++) cycle(1'b1, C_HOLD, 4);
        check_eq("hold_stays_red", int'(state), 2);
        check_eq("hold_red_sat_val", int'(red_count), 7);
        check_eq("hold_red_sat_flag", int'(red_count_sat), 1);
        idle_cycles(3, 4);
        check_eq("post_hold_red", int'(state), 2);
        cycle(1'b0, C_HOLD, 4);
        check_eq("post_hold_green", int'(state), 3);
        cycle(1'b1, C_STOP, 4);
        check_eq("stop_red_clr", int'(red_count), 0);
        check_eq("stop_sat_clr", int'(red_count_sat), 0);

        // ADVANCE coinciding with a timer match is a single step.
        cycle(1'b1, C_START, 3);
        idle_cycles(2, 3);
        cycle(1'b1, C_ADV, 3);
        check_eq("adv_match_single", int'(state), 2);
        // STOP in Green at a timer match: Idle, no lap pulse.
        cycle(1'b1, C_ADV, 3);
        idle_cycles(2, 3);
        cycle(1'b1, C_STOP, 3);
        check_eq("stop_green_idle", int'(state), 0);
        check_eq("stop_green_nodone", int'(cycle_done), 0);

        // Lowering dwell below timer+1 delays expiry until the timer wraps.
        cycle(1'b1, C_START, 8);
        idle_cycles(4, 8);
        idle_cycles(13, 2);
        check_eq("dwell_lower_wait", int'(state), 1);
        cycle(1'b0, C_HOLD, 2);
        check_eq("dwell_lower_wrap", int'(state), 2);

`ifdef COLOR_CYCLE_FSM_LAP_CNT_EN
        cycle(1'b1, C_STOP, 1);
        cycle(1'b1, C_START, 1);
        idle_cycles(9, 1);
        check_eq("lap_count_3", int'(lap_count), 3);
`endif

        // Random command/dwell mix against the model.
        for (int i = 0; i < 300; i++) begin
            cycle(($urandom_range(0, 1) == 1), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 5)));
        end

        // Reset mid-Green with timer at 2.
        cycle(1'b1, C_STOP, 0);
        cycle(1'b1, C_START, 0);
        cycle(1'b1, C_ADV, 0);
        cycle(1'b1, C_ADV, 0);
        idle_cycles(2, 0);
        check_eq("pre_reset_green", int'(state), 3);
        async_reset("mid_reset");
        cycle(1'b0, C_HOLD, 0);
        check_eq("after_reset_idle", int'(state), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
